// File: rtl/fetch_unit.sv
// Instruction fetch stage. It owns the PC, issues one 32-bit fetch at a time
// over a valid/ready instruction bus, and hands each instruction with its PC to
// the decode stage. It stalls while decode is busy. A redirect replaces the PC
// and squashes any fetch that is still in flight.
module fetch_unit #(
   parameter int unsigned       XLEN     = 64,
   parameter logic [XLEN-1:0]   RESET_PC = 64'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            ibus_req_valid,
   input  logic            ibus_req_ready,
   output logic [XLEN-1:0] ibus_addr,
   input  logic            ibus_resp_valid,
   input  logic [31:0]     ibus_resp_data,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_inst,
   input  logic            id_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            discard_q, discard_d;
   logic            req_valid_q, req_valid_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [31:0]     if_inst_q, if_inst_d;

   logic [XLEN-1:0] redirect_tgt;
   logic [XLEN-1:0] pc_next_seq;
   logic            req_hs;

   // Redirect targets are forced to word alignment.
   assign redirect_tgt = redirect_pc & ~XLEN'(3);
   assign pc_next_seq  = pc_q + XLEN'(4);
   assign req_hs       = req_valid_q & ibus_req_ready;

   // Next-state and next-output logic; a redirect takes priority in every state.
   always_comb begin
      // NOTE: every target gets a hold value first, so no path can infer a latch.
      state_d     = state_q;
      pc_d        = pc_q;
      discard_d   = discard_q;
      req_valid_d = req_valid_q;
      addr_d      = addr_q;
      if_valid_d  = if_valid_q;
      if_pc_d     = if_pc_q;
      if_inst_d   = if_inst_q;

      unique case (state_q)
         S_IDLE: begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            if (redirect_valid) begin
               pc_d   = redirect_tgt;
               addr_d = redirect_tgt;
            end else begin
               addr_d = pc_q;
            end
         end

         S_REQ: begin
            // An issued request is never retracted. A redirect only marks its
            // response for dropping.
            if (redirect_valid) begin
               pc_d      = redirect_tgt;
               discard_d = 1'b1;
            end
            if (req_hs) begin
               state_d     = S_WAIT;
               req_valid_d = 1'b0;
            end
         end

         S_WAIT: begin
            if (ibus_resp_valid) begin
               if (redirect_valid || discard_q) begin
                  // Stale or squashed response. Refetch from the current PC
                  // or from the new target.
                  discard_d   = 1'b0;
                  state_d     = S_REQ;
                  req_valid_d = 1'b1;
                  pc_d        = redirect_valid ? redirect_tgt : pc_q;
                  addr_d      = redirect_valid ? redirect_tgt : pc_q;
               end else begin
                  state_d    = S_HOLD;
                  if_valid_d = 1'b1;
                  if_pc_d    = addr_q;
                  if_inst_d  = ibus_resp_data;
               end
            end else if (redirect_valid) begin
               pc_d      = redirect_tgt;
               discard_d = 1'b1;
            end
         end

         S_HOLD: begin
            if (redirect_valid) begin
               // The held instruction is squashed even if decode takes it now.
               state_d     = S_REQ;
               if_valid_d  = 1'b0;
               req_valid_d = 1'b1;
               pc_d        = redirect_tgt;
               addr_d      = redirect_tgt;
            end else if (id_ready) begin
               state_d     = S_REQ;
               if_valid_d  = 1'b0;
               req_valid_d = 1'b1;
               pc_d        = pc_next_seq;
               addr_d      = pc_next_seq;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers, asynchronously reset to the boot PC and a nop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         discard_q   <= 1'b0;
         req_valid_q <= 1'b0;
         addr_q      <= RESET_PC;
         if_valid_q  <= 1'b0;
         if_pc_q     <= RESET_PC;
         if_inst_q   <= NOP_INST;
      end else begin
         // NOTE: non-blocking updates make all registers see pre-edge values.
         state_q     <= state_d;
         pc_q        <= pc_d;
         discard_q   <= discard_d;
         req_valid_q <= req_valid_d;
         addr_q      <= addr_d;
         if_valid_q  <= if_valid_d;
         if_pc_q     <= if_pc_d;
         if_inst_q   <= if_inst_d;
      end
   end

   assign ibus_req_valid = req_valid_q;
   assign ibus_addr      = addr_q;
   assign if_id_valid    = if_valid_q;
   assign if_id_pc       = if_pc_q;
   assign if_id_inst     = if_inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A table of per-cycle input/expected-output
// vectors covers sequential fetch, stalls, and redirects. A hand-written
// sequence covers the asynchronous reset that arrives in the middle of a fetch.
module tb_fetch_unit;

   localparam logic [63:0] R   = 64'h8000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] BAD = 32'hDEAD_BEEF;
   localparam logic [63:0] T1  = 64'h8000_0100;
   localparam logic [63:0] T2  = 64'h8000_0200;
   localparam logic [63:0] T3  = 64'h8000_0300;
   localparam logic [63:0] T4  = 64'h8000_0400;
   localparam logic [63:0] T5  = 64'h8000_0500;
   localparam logic [63:0] TM  = 64'hFFFF_FFFF_FFFF_FFFC;

   typedef struct packed {
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        idr;
      logic        redv;
      logic [63:0] rpc;
   } in_t;

   typedef struct packed {
      logic        qv;
      logic [63:0] addr;
      logic        iv;
      logic [63:0] ipc;
      logic [31:0] inst;
   } out_t;

   typedef struct packed {
      in_t  in;
      out_t exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ibus_req_valid;
   logic        ibus_req_ready;
   logic [63:0] ibus_addr;
   logic        ibus_resp_valid;
   logic [31:0] ibus_resp_data;
   logic        if_id_valid;
   logic [63:0] if_id_pc;
   logic [31:0] if_id_inst;
   logic        id_ready;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   int n_vec = 0;
   int n_err = 0;
   vec_t vecs[$];

   fetch_unit #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .ibus_req_valid  (ibus_req_valid),
      .ibus_req_ready  (ibus_req_ready),
      .ibus_addr       (ibus_addr),
      .ibus_resp_valid (ibus_resp_valid),
      .ibus_resp_data  (ibus_resp_data),
      .if_id_valid     (if_id_valid),
      .if_id_pc        (if_id_pc),
      .if_id_inst      (if_id_inst),
      .id_ready        (id_ready),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic idr, input logic redv, input logic [63:0] rpc,
                               input logic qv, input logic [63:0] addr, input logic iv,
                               input logic [63:0] ipc, input logic [31:0] inst);
      vec_t v;
      v.in  = '{rdy: rdy, rv: rv, rd: rd, idr: idr, redv: redv, rpc: rpc};
      v.exp = '{qv: qv, addr: addr, iv: iv, ipc: ipc, inst: inst};
      return v;
   endfunction

   function automatic out_t sample();
      out_t o;
      o = '{qv: ibus_req_valid, addr: ibus_addr, iv: if_id_valid, ipc: if_id_pc, inst: if_id_inst};
      return o;
   endfunction

   task automatic drive(input in_t x);
      ibus_req_ready  = x.rdy;
      ibus_resp_valid = x.rv;
      ibus_resp_data  = x.rd;
      id_ready        = x.idr;
      redirect_valid  = x.redv;
      redirect_pc     = x.rpc;
   endtask

   task automatic check(input string name, input out_t act, input out_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got req_valid=%0b addr=%h if_valid=%0b pc=%h inst=%h; expected req_valid=%0b addr=%h if_valid=%0b pc=%h inst=%h",
                  name, act.qv, act.addr, act.iv, act.ipc, act.inst,
                  exp.qv, exp.addr, exp.iv, exp.ipc, exp.inst);
      end
   endtask

   initial begin
      // Sequential fetch, bus responds one cycle after each handshake.
      vecs.push_back(mk(0,0,0,           0,0,0,            1,R,0,R,NOP));
      vecs.push_back(mk(1,0,0,           0,0,0,            0,R,0,R,NOP));
      vecs.push_back(mk(0,1,32'hA0A0_0000,0,0,0,           0,R,1,R,32'hA0A0_0000));
      vecs.push_back(mk(0,0,0,           1,0,0,            1,R+4,0,R,32'hA0A0_0000));
      vecs.push_back(mk(1,0,0,           0,0,0,            0,R+4,0,R,32'hA0A0_0000));
      vecs.push_back(mk(0,1,32'hA1A1_0001,0,0,0,           0,R+4,1,R+4,32'hA1A1_0001));
      vecs.push_back(mk(0,0,0,           1,0,0,            1,R+8,0,R+4,32'hA1A1_0001));
      vecs.push_back(mk(1,0,0,           0,0,0,            0,R+8,0,R+4,32'hA1A1_0001));
      vecs.push_back(mk(0,1,32'hA2A2_0002,0,0,0,           0,R+8,1,R+8,32'hA2A2_0002));
      // Decode stalls for five cycles. Output stays stable and no new request is issued.
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1,0,0,        0,0,0,            0,R+8,1,R+8,32'hA2A2_0002));
      vecs.push_back(mk(0,0,0,           1,0,0,            1,R+12,0,R+8,32'hA2A2_0002));
      // Bus is not ready for four cycles. The request is held at the same address.
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0,0,0,        0,0,0,            1,R+12,0,R+8,32'hA2A2_0002));
      vecs.push_back(mk(1,0,0,           0,0,0,            0,R+12,0,R+8,32'hA2A2_0002));
      vecs.push_back(mk(0,1,32'hA3A3_0003,0,0,0,           0,R+12,1,R+12,32'hA3A3_0003));
      vecs.push_back(mk(0,0,0,           1,0,0,            1,R+16,0,R+12,32'hA3A3_0003));
      vecs.push_back(mk(1,0,0,           0,0,0,            0,R+16,0,R+12,32'hA3A3_0003));
      // Redirect to an unaligned target during WAIT. The old response is dropped.
      vecs.push_back(mk(0,0,0,           0,1,64'h8000_0103, 0,R+16,0,R+12,32'hA3A3_0003));
      vecs.push_back(mk(0,1,BAD,         0,0,0,            1,T1,0,R+12,32'hA3A3_0003));
      vecs.push_back(mk(1,0,0,           0,0,0,            0,T1,0,R+12,32'hA3A3_0003));
      vecs.push_back(mk(0,1,32'hA4A4_0004,0,0,0,           0,T1,1,T1,32'hA4A4_0004));
      // Redirect in HOLD while id_ready=1. The held instruction is squashed.
      vecs.push_back(mk(0,0,0,           1,1,64'h8000_0202, 1,T2,0,T1,32'hA4A4_0004));
      // Redirect in REQ while the bus is not ready. The address is held and the response discarded.
      vecs.push_back(mk(0,0,0,           0,1,64'h8000_0300, 1,T2,0,T1,32'hA4A4_0004));
      vecs.push_back(mk(1,0,0,           0,0,0,            0,T2,0,T1,32'hA4A4_0004));
      vecs.push_back(mk(0,1,BAD,         0,0,0,            1,T3,0,T1,32'hA4A4_0004));
      vecs.push_back(mk(1,0,0,           0,0,0,            0,T3,0,T1,32'hA4A4_0004));
      vecs.push_back(mk(0,1,32'hA5A5_0005,0,0,0,           0,T3,1,T3,32'hA5A5_0005));
      // Redirect on the same edge as the WAIT response.
      vecs.push_back(mk(0,0,0,           1,0,0,            1,T3+4,0,T3,32'hA5A5_0005));
      vecs.push_back(mk(1,0,0,           0,0,0,            0,T3+4,0,T3,32'hA5A5_0005));
      vecs.push_back(mk(0,1,BAD,         0,1,64'h8000_0401, 1,T4,0,T3,32'hA5A5_0005));
      vecs.push_back(mk(1,0,0,           0,0,0,            0,T4,0,T3,32'hA5A5_0005));
      vecs.push_back(mk(0,1,32'hA6A6_0006,0,0,0,           0,T4,1,T4,32'hA6A6_0006));
      // Redirect on the same edge as the request handshake.
      vecs.push_back(mk(0,0,0,           1,0,0,            1,T4+4,0,T4,32'hA6A6_0006));
      vecs.push_back(mk(1,0,0,           0,1,T5,           0,T4+4,0,T4,32'hA6A6_0006));
      vecs.push_back(mk(0,1,BAD,         0,0,0,            1,T5,0,T4,32'hA6A6_0006));
      vecs.push_back(mk(1,0,0,           0,0,0,            0,T5,0,T4,32'hA6A6_0006));
      vecs.push_back(mk(0,1,32'hA7A7_0007,0,0,0,           0,T5,1,T5,32'hA7A7_0007));
      // The PC wraps around the top of the address space.
      vecs.push_back(mk(0,0,0,           1,1,64'hFFFF_FFFF_FFFF_FFFF, 1,TM,0,T5,32'hA7A7_0007));
      vecs.push_back(mk(1,0,0,           0,0,0,            0,TM,0,T5,32'hA7A7_0007));
      vecs.push_back(mk(0,1,32'hA8A8_0008,0,0,0,           0,TM,1,TM,32'hA8A8_0008));
      vecs.push_back(mk(0,0,0,           1,0,0,            1,64'h0,0,TM,32'hA8A8_0008));

      rst = 1'b0;
      drive('0);
      #12;
      check("reset_values", sample(), '{qv: 1'b0, addr: R, iv: 1'b0, ipc: R, inst: NOP});
      // Release reset clear of any clock edge. The next rising edge is the first vector.
      @(posedge clk);
      #2 rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].in);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), sample(), vecs[i].exp);
      end

      // Asynchronous reset in the middle of WAIT, with a stale response present during reset.
      @(negedge clk);
      drive('{rdy: 1'b1, rv: 1'b0, rd: 32'h0, idr: 1'b0, redv: 1'b0, rpc: 64'h0});
      @(posedge clk);
      #1;
      check("enter_wait", sample(), '{qv: 1'b0, addr: 64'h0, iv: 1'b0, ipc: TM, inst: 32'hA8A8_0008});
      #2;
      rst = 1'b0;
      drive('{rdy: 1'b0, rv: 1'b1, rd: BAD, idr: 1'b1, redv: 1'b0, rpc: 64'h0});
      #1;
      check("async_reset", sample(), '{qv: 1'b0, addr: R, iv: 1'b0, ipc: R, inst: NOP});
      @(posedge clk);
      #1;
      check("reset_stale_resp", sample(), '{qv: 1'b0, addr: R, iv: 1'b0, ipc: R, inst: NOP});
      #1;
      rst = 1'b1;
      drive('0);
      @(posedge clk);
      #1;
      check("refetch_req", sample(), '{qv: 1'b1, addr: R, iv: 1'b0, ipc: R, inst: NOP});
      @(negedge clk);
      drive('{rdy: 1'b1, rv: 1'b0, rd: 32'h0, idr: 1'b0, redv: 1'b0, rpc: 64'h0});
      @(posedge clk);
      #1;
      check("refetch_wait", sample(), '{qv: 1'b0, addr: R, iv: 1'b0, ipc: R, inst: NOP});
      @(negedge clk);
      drive('{rdy: 1'b0, rv: 1'b1, rd: 32'hA9A9_0009, idr: 1'b0, redv: 1'b0, rpc: 64'h0});
      @(posedge clk);
      #1;
      check("refetch_hold", sample(), '{qv: 1'b0, addr: R, iv: 1'b1, ipc: R, inst: 32'hA9A9_0009});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
